// File: rtl/ysyx_23060240_ifu_pf.sv
// ysyx_23060240_ifu_pf: prefetching instruction fetch unit.
// Issues in-order word fetches over a valid/ready request channel and buffers
// {pc, inst} pairs in a DEPTH-entry FIFO. The FIFO feeds IDU through a
// valid/ready handshake. A redirect (jump_en) flushes the FIFO and discards
// responses that are still in flight.
// Optional feature: define YSYX_23060240_IFU_PERF_EN to build the three
// saturating performance counters. When it is undefined, the perf outputs
// are tied to zero.
module ysyx_23060240_ifu_pf #(
   parameter int              XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = XLEN'(32'h8000_0000),
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   input  logic            resp_valid,
   input  logic [31:0]     resp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] pc,
   input  logic            jump_en,
   input  logic [XLEN-1:0] jump_pc,
   output logic [31:0]     perf_fetch,
   output logic [31:0]     perf_flush,
   output logic [31:0]     perf_stall
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [XLEN-1:0] jump_target;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   outstanding_nxt;
   logic [OW-1:0]   drop_cnt;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [31:0]     in_flight;
   logic            credit_ok;
   logic            req_fire;
   logic            resp_fire;
   logic            push;
   logic            pop;

   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [31:0]     inst_mem [DEPTH];

   // Issue credit, handshake qualification and the FIFO head view.
   // NOTE: every signal written in always_comb gets a value on every path so no latch is inferred.
   always_comb begin
      jump_target     = jump_pc & ~XLEN'(3);
      // Entries already buffered plus live (not-to-be-dropped) requests must fit the FIFO.
      in_flight       = 32'(count) + 32'(outstanding) - 32'(drop_cnt);
      credit_ok       = (32'(outstanding) < 32'(MAX_OUTSTANDING)) && (in_flight < 32'(DEPTH));
      req_valid       = rst && credit_ok;
      req_addr        = fetch_pc;
      req_fire        = req_valid && req_ready;
      // A response with nothing outstanding is a protocol error and is ignored.
      resp_fire       = resp_valid && (outstanding != '0);
      push            = resp_fire && (drop_cnt == '0) && !jump_en;
      inst_valid      = (count != '0);
      pop             = inst_valid && inst_ready && !jump_en;
      outstanding_nxt = outstanding + OW'(req_fire) - OW'(resp_fire);
      inst            = inst_valid ? inst_mem[rd_ptr] : 32'd0;
      pc              = inst_valid ? pc_mem[rd_ptr]   : '0;
   end

   // Fetch address and the pc tag of the next kept response.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
      end else if (jump_en) begin
         fetch_pc <= jump_target;
         resp_pc  <= jump_target;
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
         if (push)     resp_pc  <= resp_pc + PC_STEP;
      end
   end

   // Outstanding request count and number of stale responses still to discard.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (jump_en)              drop_cnt <= outstanding_nxt;
         else if (resp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
      end
   end

   // FIFO occupancy and pointers; a redirect empties the FIFO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (jump_en) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage written on each kept response.
   // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= resp_pc;
         inst_mem[wr_ptr] <= resp_data;
      end
   end

`ifdef YSYX_23060240_IFU_PERF_EN
   logic [31:0] fetch_q;
   logic [31:0] flush_q;
   logic [31:0] stall_q;

   // Saturating event counters: kept responses, redirects, IDU starvation cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_q <= '0;
         flush_q <= '0;
         stall_q <= '0;
      end else begin
         if (push && (fetch_q != '1))                   fetch_q <= fetch_q + 32'd1;
         if (jump_en && (flush_q != '1))                flush_q <= flush_q + 32'd1;
         if (inst_ready && !inst_valid && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      end
   end

   assign perf_fetch = fetch_q;
   assign perf_flush = flush_q;
   assign perf_stall = stall_q;
`else
   assign perf_fetch = 32'd0;
   assign perf_flush = 32'd0;
   assign perf_stall = 32'd0;
`endif

`ifndef SYNTHESIS
   // Protocol checks: unexpected responses and FIFO overflow.
   always @(posedge clk) begin
      if (rst) begin
         assert (!(resp_valid && (outstanding == '0)))
            else $error("ifu_pf: resp_valid with no outstanding request");
         assert (!(push && !pop && (count == CW'(DEPTH))))
            else $error("ifu_pf: push into full FIFO");
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_23060240_ifu_pf.sv
// Testbench for ysyx_23060240_ifu_pf: a table of per-cycle directed vectors,
// then hand-written sequences for a full FIFO, a randomised 3-cycle-latency
// memory with redirects, and an asynchronous reset in mid-stream.
module tb_ysyx_23060240_ifu_pf;

   localparam logic [31:0] B       = 32'h8000_0000;
   localparam int          MAX_OUT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, pc;
   logic        jump_en;
   logic [31:0] jump_pc;
   logic [31:0] perf_fetch, perf_flush, perf_stall;

   ysyx_23060240_ifu_pf #(
      .XLEN(32), .RESET_PC(B), .DEPTH(4), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
      .jump_en(jump_en), .jump_pc(jump_pc),
      .perf_fetch(perf_fetch), .perf_flush(perf_flush), .perf_stall(perf_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rr;   logic rv; logic [31:0] rd;
      logic        ir;   logic je; logic [31:0] jp;
      logic        e_rv; logic [31:0] e_addr;
      logic        e_iv; logic [31:0] e_pc; logic [31:0] e_inst;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] rd,
                               input logic ir, input logic je, input logic [31:0] jp,
                               input logic e_rv, input logic [31:0] e_addr,
                               input logic e_iv, input logic [31:0] e_pc,
                               input logic [31:0] e_inst);
      vec_t v;
      v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir; v.je = je; v.jp = jp;
      v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc; v.e_inst = e_inst;
      return v;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_5A5A;
   endfunction

   task automatic drive_idle();
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_data  = 32'd0;
      inst_ready = 1'b0;
      jump_en    = 1'b0;
      jump_pc    = 32'd0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Global watchdog so the run always ends.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [20];
      mreq_t       mq [$];
      int          accepted;
      logic        pend;
      logic [31:0] pend_addr;
      int          cyc;
      int          consumed;
      logic [31:0] exp_pc;
      logic        j;

      // Cycle-by-cycle table from reset release: 1-cycle memory echoing the
      // address, a redirect with two requests in flight (c6), and a redirect
      // coinciding with a response and an IDU pop (c13).
      //              rr  rv  rd          ir  je  jp          | rv  addr        iv  pc          inst
      vecs[0]  = mk(1, 0, 0,          1, 0, 0,           1, B,          0, 0,          0);
      vecs[1]  = mk(1, 1, B,          1, 0, 0,           1, B+32'h4,    0, 0,          0);
      vecs[2]  = mk(1, 1, B+32'h4,    1, 0, 0,           1, B+32'h8,    1, B,          B);
      vecs[3]  = mk(0, 1, B+32'h8,    0, 0, 0,           1, B+32'hC,    1, B+32'h4,    B+32'h4);
      vecs[4]  = mk(1, 0, 0,          0, 0, 0,           1, B+32'hC,    1, B+32'h4,    B+32'h4);
      vecs[5]  = mk(1, 0, 0,          0, 0, 0,           1, B+32'h10,   1, B+32'h4,    B+32'h4);
      vecs[6]  = mk(1, 0, 0,          0, 1, B+32'h102,   0, B+32'h14,   1, B+32'h4,    B+32'h4);
      vecs[7]  = mk(1, 1, B+32'hC,    1, 0, 0,           0, B+32'h100,  0, 0,          0);
      vecs[8]  = mk(1, 1, B+32'h10,   1, 0, 0,           1, B+32'h100,  0, 0,          0);
      vecs[9]  = mk(0, 1, B+32'h100,  1, 0, 0,           1, B+32'h104,  0, 0,          0);
      vecs[10] = mk(0, 0, 0,          1, 0, 0,           1, B+32'h104,  1, B+32'h100,  B+32'h100);
      vecs[11] = mk(1, 0, 0,          1, 0, 0,           1, B+32'h104,  0, 0,          0);
      vecs[12] = mk(1, 1, B+32'h104,  1, 0, 0,           1, B+32'h108,  0, 0,          0);
      vecs[13] = mk(1, 1, B+32'h108,  1, 1, B+32'h203,   1, B+32'h10C,  1, B+32'h104,  B+32'h104);
      vecs[14] = mk(1, 0, 0,          1, 0, 0,           1, B+32'h200,  0, 0,          0);
      vecs[15] = mk(1, 1, B+32'h10C,  1, 0, 0,           0, B+32'h204,  0, 0,          0);
      vecs[16] = mk(1, 1, B+32'h200,  1, 0, 0,           1, B+32'h204,  0, 0,          0);
      vecs[17] = mk(0, 1, B+32'h204,  1, 0, 0,           1, B+32'h208,  1, B+32'h200,  B+32'h200);
      vecs[18] = mk(0, 0, 0,          1, 0, 0,           1, B+32'h208,  1, B+32'h204,  B+32'h204);
      vecs[19] = mk(0, 0, 0,          0, 0, 0,           1, B+32'h208,  0, 0,          0);

      // Reset state, observed while rst is held low.
      drive_idle();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_valid",  req_valid,  0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_pc",         pc,         0);
      check("rst_inst",       inst,       0);
      check("rst_req_addr",   req_addr,   B);
      check("rst_perf_fetch", perf_fetch, 0);
      check("rst_perf_flush", perf_flush, 0);
      check("rst_perf_stall", perf_stall, 0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Directed table.
      for (int i = 0; i < 20; i++) begin
         req_ready  = vecs[i].rr;
         resp_valid = vecs[i].rv;
         resp_data  = vecs[i].rd;
         inst_ready = vecs[i].ir;
         jump_en    = vecs[i].je;
         jump_pc    = vecs[i].jp;
         @(negedge clk);
         check($sformatf("v%0d_req_valid", i),  req_valid,  vecs[i].e_rv);
         check($sformatf("v%0d_req_addr", i),   req_addr,   vecs[i].e_addr);
         check($sformatf("v%0d_inst_valid", i), inst_valid, vecs[i].e_iv);
         check($sformatf("v%0d_pc", i),         pc,         vecs[i].e_pc);
         check($sformatf("v%0d_inst", i),       inst,       vecs[i].e_inst);
         @(posedge clk);
         #1;
      end
`ifdef YSYX_23060240_IFU_PERF_EN
      check("tbl_perf_fetch", perf_fetch, 7);
      check("tbl_perf_flush", perf_flush, 2);
      check("tbl_perf_stall", perf_stall, 10);
`else
      check("tbl_perf_fetch", perf_fetch, 0);
      check("tbl_perf_flush", perf_flush, 0);
      check("tbl_perf_stall", perf_stall, 0);
`endif

      // Full FIFO: IDU stalled, 1-cycle memory echoing the address.
      do_reset();
      accepted  = 0;
      pend      = 1'b0;
      pend_addr = 32'd0;
      for (int c = 0; c < 12; c++) begin
         req_ready  = 1'b1;
         inst_ready = 1'b0;
         resp_valid = pend;
         resp_data  = pend_addr;
         @(negedge clk);
         pend      = req_valid && req_ready;
         pend_addr = req_addr;
         if (pend) accepted++;
         @(posedge clk);
         #1;
      end
      check("full_accepted", accepted, 4);
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      @(negedge clk);
      check("full_req_valid",  req_valid,  0);
      check("full_inst_valid", inst_valid, 1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         inst_ready = 1'b1;
         @(negedge clk);
         check($sformatf("full_pop%0d_valid", i), inst_valid, 1);
         check($sformatf("full_pop%0d_pc", i),    pc,   B + 32'(4 * i));
         check($sformatf("full_pop%0d_inst", i),  inst, B + 32'(4 * i));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("full_drained", inst_valid, 0);
      @(posedge clk);
      #1;
      inst_ready = 1'b0;

      // Random traffic: 3-cycle in-order memory, random req_ready, IDU
      // back-pressure and redirects, against a sequential pc model.
      do_reset();
      cyc      = 0;
      consumed = 0;
      exp_pc   = B;
      while (consumed < 1000 && cyc < 20000) begin
         j          = ($urandom_range(0, 39) == 0);
         jump_en    = j;
         jump_pc    = {16'h8000, 16'($urandom_range(0, 65535))};
         req_ready  = 1'($urandom_range(0, 1));
         inst_ready = j ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = mem_word(mq[0].addr);
         end else begin
            resp_valid = 1'b0;
            resp_data  = 32'd0;
         end
         @(negedge clk);
         if (inst_valid && inst_ready) begin
            check("rnd_pc",   pc,   exp_pc);
            check("rnd_inst", inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (j) exp_pc = {jump_pc[31:2], 2'b00};
         if (resp_valid) void'(mq.pop_front());
         if (req_valid && req_ready) mq.push_back('{addr: req_addr, due: cyc + 3});
         check("rnd_outstanding_bound", (mq.size() <= MAX_OUT), 1);
         @(posedge clk);
         #1;
         cyc++;
      end
      check("rnd_completed", (consumed >= 1000), 1);

      // Asynchronous reset in mid-stream, between clock edges.
      #3 rst = 1'b0;
      #1;
      check("arst_req_valid",  req_valid,  0);
      check("arst_inst_valid", inst_valid, 0);
      check("arst_pc",         pc,         0);
      check("arst_inst",       inst,       0);
      check("arst_perf_fetch", perf_fetch, 0);
      check("arst_perf_flush", perf_flush, 0);
      check("arst_perf_stall", perf_stall, 0);
      mq.delete();
      drive_idle();
      @(posedge clk);
      #1 rst = 1'b1;
      req_ready = 1'b1;
      @(negedge clk);
      check("rerun_req_valid", req_valid, 1);
      check("rerun_req_addr",  req_addr,  B);
      @(posedge clk);
      #1;
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      resp_data  = mem_word(B);
      @(posedge clk);
      #1;
      resp_valid = 1'b0;
      @(negedge clk);
      check("rerun_inst_valid", inst_valid, 1);
      check("rerun_pc",         pc,         B);
      check("rerun_inst",       inst,       mem_word(B));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
